pitch_unit_sequencer: RTL and testbench
=======================================

PITCH_UNIT_SEQUENCER -- requirements
Module: pitch_unit_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the status counters.
REQ-002 Port: clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 Port: reset_n  in  1  reset, synchronous and active-low.
REQ-004 Port: cfg_unit  in  8  PITCH unit number accepted; sampled in DECIDE.
REQ-005 Port: udp_data  in  8  UDP payload byte.
REQ-006 Port: udp_valid  in  1  udp_data valid.
REQ-007 Port: udp_last  in  1  marks final byte of datagram; qualified by udp_valid.
REQ-008 Port: udp_ready  out  1  byte accepted when udp_valid & udp_ready.
REQ-009 Port: parser_data  out  8  byte to bats parser data input.
REQ-010 Port: parser_data_valid  out  1  bats parser data_valid.
REQ-011 Port: parser_ready  in  1  bats parser Ready_for_Udp_Input.
REQ-012 Port: parser_reset  out  1  one-cycle pulse to bats parser reset.
REQ-013 Port: expected_seq  out  32  next expected sequence number.
REQ-014 Port: gap_count, dup_count, err_count  out  CNT_W each  saturating status counters.

Function
REQ-015 Datagram layout SHALL be: 8-byte header (length[15:0] LE, count[7:0], unit[7:0], seq[31:0] LE), then count messages, each starting with a length byte L (includes itself).
REQ-016 States SHALL be IDLE, HDR, DECIDE, SKIP, FWD, DRAIN; IDLE->HDR on first accepted byte (that byte is header byte 0).
REQ-017 HDR SHALL capture 8 bytes; on 8th byte -> DECIDE; udp_last before 8th byte -> IDLE, err_count+1, nothing forwarded.
REQ-018 DECIDE SHALL last exactly one cycle with udp_ready=0; end = seq+count computed 33-bit.
REQ-019 DECIDE: unit!=cfg_unit -> DRAIN, no counters; end<=expected_seq -> DRAIN, dup_count+1; seq>expected_seq -> gap_count+1, skip=0, expected_seq<=end[31:0]; seq<expected_seq<end -> dup_count+1, skip=expected_seq-seq, expected_seq<=end[31:0]; seq==expected_seq -> skip=0, expected_seq<=end[31:0].
REQ-020 After DECIDE (non-DRAIN): count==0 -> DRAIN; skip>0 -> SKIP; else FWD.
REQ-021 SKIP SHALL consume bytes without forwarding, tracking message boundaries via L; after skip messages -> FWD, or DRAIN if none remain.
REQ-022 FWD SHALL forward every byte of each remaining message; after last byte of message count -> DRAIN.
REQ-023 L<2 in SKIP or FWD SHALL be malformed: err_count+1, -> DRAIN; if in FWD, that byte is not forwarded and parser_reset pulses.
REQ-024 DRAIN SHALL accept and discard bytes (udp_ready=1) until udp_last, then -> IDLE.
REQ-025 udp_last in SKIP/FWD before all messages complete: err_count+1, -> IDLE; if any byte of an incomplete message was forwarded, parser_reset SHALL pulse once, one cycle after that byte leaves the output register.
REQ-026 Output SHALL be one register stage: forwarded byte appears on parser_data/parser_data_valid the cycle after acceptance (latency 1).
REQ-027 Output register SHALL hold while parser_data_valid & !parser_ready; udp_ready in FWD = !parser_data_valid | parser_ready; in IDLE/HDR/SKIP/DRAIN udp_ready=1, DECIDE 0.
REQ-028 A byte transfers to the parser only on parser_data_valid & parser_ready; no byte lost or duplicated under any backpressure pattern.
REQ-029 expected_seq SHALL wrap modulo 2^32; comparisons unsigned, not wrap-aware.
REQ-030 Status counters SHALL saturate at all-ones; simultaneous increments to different counters both apply.
REQ-031 Extra bytes after header length are ignored (DRAIN); header length field is not checked.

Reset
REQ-032 reset_n=0 on a clock edge SHALL force IDLE, expected_seq=1, all counters 0, parser_data_valid=0, parser_data=0, parser_reset=0, udp_ready=0 during reset.
REQ-033 Reset mid-datagram SHALL abandon it; post-reset bytes are treated as a new datagram header; parser_reset SHALL pulse one cycle after reset release.

Verification
REQ-034 Unit 1, seq 1, count 2 (Add Order L=26, Delete Order L=14), parser_ready=1 -> 40 bytes out, latency 1, expected_seq=3, counters 0.
REQ-035 Repeat same datagram -> 0 bytes out, dup_count=1, expected_seq=3; then seq 5 count 1 -> gap_count=1, message forwarded, expected_seq=6.
REQ-036 Seq 4 count 3 with expected_seq=6 -> first 2 messages skipped, third forwarded, dup_count+1, expected_seq=7.
REQ-037 Random parser_ready (50%) on 3-message datagram -> byte-exact output sequence, udp_ready never 1 while output held.
REQ-038 udp_last mid-message in FWD -> err_count=1, parser_reset single pulse, IDLE; unit=2 with cfg_unit=1 -> drained, nothing forwarded, counters unchanged.
REQ-039 5-byte runt datagram -> err_count+1, no output; CNT_W=2 with 5 duplicates -> dup_count=3.

Source files
------------

// File: rtl/pitch_unit_sequencer.sv
// rtl/pitch_unit_sequencer.sv - PITCH datagram sequencer: seq gap/dup filtering, message forwarding to bats parser
module pitch_unit_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       cfg_unit,
    input  logic [7:0]       udp_data,
    input  logic             udp_valid,
    input  logic             udp_last,
    output logic             udp_ready,
    output logic [7:0]       parser_data,
    output logic             parser_data_valid,
    input  logic             parser_ready,
    output logic             parser_reset,
    output logic [31:0]      expected_seq,
    output logic [CNT_W-1:0] gap_count,
    output logic [CNT_W-1:0] dup_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DECIDE, S_SKIP, S_FWD, S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_n;
    logic [2:0]  hdr_idx, hdr_idx_n;
    logic [7:0]  hdr_count, hdr_count_n;
    logic [7:0]  hdr_unit, hdr_unit_n;
    logic [31:0] hdr_seq, hdr_seq_n;
    logic        hdr_last, hdr_last_n;
    logic [7:0]  msg_rem, msg_rem_n;
    logic [7:0]  skip_rem, skip_rem_n;
    logic [7:0]  byte_rem, byte_rem_n;
    logic [31:0] expected_seq_n;
    logic        rst_pend, rst_pend_n;
    logic        rst_set, rst_fire;
    logic        post_reset;
    logic        inc_gap, inc_dup, inc_err;
    logic        fwd_load;
    logic        accept;

    logic [32:0] seq_end;
    logic [7:0]  skip_msgs;
    logic        msg_start, msg_bad, msg_done, final_msg;
    logic [7:0]  byte_rem_next;

    assign seq_end       = {1'b0, hdr_seq} + {25'd0, hdr_count};
    // skip is always below count (<=255), so the low byte of the difference is exact
    assign skip_msgs     = expected_seq[7:0] - hdr_seq[7:0];
    assign msg_start     = (byte_rem == 8'd0);
    assign msg_bad       = msg_start && (udp_data < 8'd2);
    assign msg_done      = !msg_start && (byte_rem == 8'd1);
    assign final_msg     = (msg_rem == 8'd1);
    assign byte_rem_next = msg_start ? (udp_data - 8'd1) : (byte_rem - 8'd1);

    // A pending parser reset waits until the output register has nothing left for the parser
    assign rst_fire = rst_pend && (!parser_data_valid || parser_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n        = state;
        hdr_idx_n      = hdr_idx;
        hdr_count_n    = hdr_count;
        hdr_unit_n     = hdr_unit;
        hdr_seq_n      = hdr_seq;
        hdr_last_n     = hdr_last;
        msg_rem_n      = msg_rem;
        skip_rem_n     = skip_rem;
        byte_rem_n     = byte_rem;
        expected_seq_n = expected_seq;
        inc_gap        = 1'b0;
        inc_dup        = 1'b0;
        inc_err        = 1'b0;
        fwd_load       = 1'b0;
        rst_set        = 1'b0;

        case (state)
            S_IDLE, S_HDR, S_SKIP, S_DRAIN: udp_ready = reset_n;
            S_FWD:   udp_ready = reset_n && (!parser_data_valid || parser_ready);
            default: udp_ready = 1'b0;
        endcase
        accept = udp_valid && udp_ready;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (udp_last) begin
                        inc_err = 1'b1;
                    end else begin
                        state_n   = S_HDR;
                        hdr_idx_n = 3'd1;
                    end
                end
            end
            S_HDR: begin
                if (accept) begin
                    case (hdr_idx)
                        3'd2:    hdr_count_n       = udp_data;
                        3'd3:    hdr_unit_n        = udp_data;
                        3'd4:    hdr_seq_n[7:0]    = udp_data;
                        3'd5:    hdr_seq_n[15:8]   = udp_data;
                        3'd6:    hdr_seq_n[23:16]  = udp_data;
                        3'd7:    hdr_seq_n[31:24]  = udp_data;
                        default: ;
                    endcase
                    if (hdr_idx == 3'd7) begin
                        state_n    = S_DECIDE;
                        hdr_last_n = udp_last;
                    end else if (udp_last) begin
                        inc_err = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        hdr_idx_n = hdr_idx + 3'd1;
                    end
                end
            end
            S_DECIDE: begin
                msg_rem_n  = hdr_count;
                skip_rem_n = 8'd0;
                byte_rem_n = 8'd0;
                state_n    = hdr_last ? S_IDLE : S_DRAIN;
                if (hdr_unit != cfg_unit) begin
                    state_n = hdr_last ? S_IDLE : S_DRAIN;
                end else if (seq_end <= {1'b0, expected_seq}) begin
                    inc_dup = 1'b1;
                end else begin
                    expected_seq_n = seq_end[31:0];
                    if (hdr_seq > expected_seq) begin
                        inc_gap = 1'b1;
                    end else if (hdr_seq < expected_seq) begin
                        inc_dup    = 1'b1;
                        skip_rem_n = skip_msgs;
                    end
                    if (hdr_count != 8'd0) begin
                        if (hdr_last) begin
                            // header-only datagram that promised messages
                            inc_err = 1'b1;
                            state_n = S_IDLE;
                        end else if (hdr_seq < expected_seq) begin
                            state_n = S_SKIP;
                        end else begin
                            state_n = S_FWD;
                        end
                    end
                end
            end
            S_SKIP: begin
                if (accept) begin
                    if (msg_bad) begin
                        inc_err = 1'b1;
                        state_n = udp_last ? S_IDLE : S_DRAIN;
                    end else begin
                        byte_rem_n = byte_rem_next;
                        if (msg_done) begin
                            msg_rem_n  = msg_rem - 8'd1;
                            skip_rem_n = skip_rem - 8'd1;
                        end
                        if (udp_last) begin
                            inc_err = !(msg_done && final_msg);
                            state_n = S_IDLE;
                        end else if (msg_done && skip_rem == 8'd1) begin
                            state_n = final_msg ? S_DRAIN : S_FWD;
                        end
                    end
                end
            end
            S_FWD: begin
                if (accept) begin
                    if (msg_bad) begin
                        inc_err = 1'b1;
                        rst_set = 1'b1;
                        state_n = udp_last ? S_IDLE : S_DRAIN;
                    end else begin
                        fwd_load   = 1'b1;
                        byte_rem_n = byte_rem_next;
                        if (msg_done) begin
                            msg_rem_n = msg_rem - 8'd1;
                        end
                        if (msg_done && final_msg) begin
                            state_n = udp_last ? S_IDLE : S_DRAIN;
                        end else if (udp_last) begin
                            inc_err = 1'b1;
                            rst_set = !msg_done;
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept && udp_last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        rst_pend_n = rst_set || (rst_pend && !rst_fire);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hdr_idx           <= 3'd0;
            hdr_count         <= 8'd0;
            hdr_unit          <= 8'd0;
            hdr_seq           <= 32'd0;
            hdr_last          <= 1'b0;
            msg_rem           <= 8'd0;
            skip_rem          <= 8'd0;
            byte_rem          <= 8'd0;
            expected_seq      <= 32'd1;
            parser_data       <= 8'd0;
            parser_data_valid <= 1'b0;
            parser_reset      <= 1'b0;
            post_reset        <= 1'b1;
            rst_pend          <= 1'b0;
            gap_count         <= '0;
            dup_count         <= '0;
            err_count         <= '0;
        end else begin
            hdr_idx      <= hdr_idx_n;
            hdr_count    <= hdr_count_n;
            hdr_unit     <= hdr_unit_n;
            hdr_seq      <= hdr_seq_n;
            hdr_last     <= hdr_last_n;
            msg_rem      <= msg_rem_n;
            skip_rem     <= skip_rem_n;
            byte_rem     <= byte_rem_n;
            expected_seq <= expected_seq_n;
            if (fwd_load) begin
                parser_data       <= udp_data;
                parser_data_valid <= 1'b1;
            end else if (parser_ready) begin
                parser_data_valid <= 1'b0;
            end
            parser_reset <= post_reset || rst_fire;
            post_reset   <= 1'b0;
            rst_pend     <= rst_pend_n;
            if (inc_gap && gap_count != CNT_MAX) gap_count <= gap_count + CNT_ONE;
            if (inc_dup && dup_count != CNT_MAX) dup_count <= dup_count + CNT_ONE;
            if (inc_err && err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pitch_unit_sequencer.sv
// tb/tb_pitch_unit_sequencer.sv - scoreboard bench for pitch_unit_sequencer against a datagram-level model
module tb_pitch_unit_sequencer;

    localparam logic [7:0] CFG = 8'd1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  cfg_unit;
    logic [7:0]  udp_data;
    logic        udp_valid;
    logic        udp_last;
    logic        udp_ready;
    logic [7:0]  parser_data;
    logic        parser_data_valid;
    logic        parser_ready;
    logic        parser_reset;
    logic [31:0] expected_seq;
    logic [15:0] gap_count, dup_count, err_count;

    logic        d2_udp_ready, d2_pdv, d2_preset;
    logic [7:0]  d2_pdata;
    logic [31:0] d2_exp;
    logic [1:0]  d2_gap, d2_dup, d2_err;

    pitch_unit_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_unit(cfg_unit),
        .udp_data(udp_data), .udp_valid(udp_valid), .udp_last(udp_last), .udp_ready(udp_ready),
        .parser_data(parser_data), .parser_data_valid(parser_data_valid),
        .parser_ready(parser_ready), .parser_reset(parser_reset),
        .expected_seq(expected_seq), .gap_count(gap_count), .dup_count(dup_count), .err_count(err_count)
    );

    pitch_unit_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_unit(cfg_unit),
        .udp_data(udp_data), .udp_valid(udp_valid), .udp_last(udp_last), .udp_ready(d2_udp_ready),
        .parser_data(d2_pdata), .parser_data_valid(d2_pdv),
        .parser_ready(parser_ready), .parser_reset(d2_preset),
        .expected_seq(d2_exp), .gap_count(d2_gap), .dup_count(d2_dup), .err_count(d2_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] dg[$];
    bit         fw[$];
    int         lens[$];

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     out_cnt = 0;
    int     prst_seen = 0;
    bit     rnd_rdy = 0;
    longint m_exp = 1;
    int     m_gap = 0, m_dup = 0, m_err = 0, m_prst = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        parser_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            parser_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: every parser transfer pops the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && parser_data_valid && parser_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {56'd0, parser_data}, 64'd256);
            end else begin
                e = exp_q.pop_front();
                out_cnt++;
                chk("parser_data", parser_data, e.d);
                if (!rnd_rdy) chk("latency", cyc, e.acc);
            end
        end
        if (parser_reset) prst_seen++;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    // Reference: walk the datagram by its layout and decide which bytes reach the parser
    task automatic model_dgram();
        int n, pos, cnt, skip, L;
        longint seq, fin;
        n = dg.size();
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back(1'b0);
        if (n < 8) begin m_err++; return; end
        cnt = dg[2];
        seq = {dg[7], dg[6], dg[5], dg[4]};
        if (dg[3] != CFG) return;
        fin = seq + cnt;
        if (fin <= m_exp) begin m_dup++; return; end
        skip = 0;
        if (seq > m_exp) m_gap++;
        else if (seq < m_exp) begin m_dup++; skip = int'(m_exp - seq); end
        m_exp = fin % 64'h1_0000_0000;
        pos = 8;
        for (int m = 0; m < cnt; m++) begin
            if (pos >= n) begin m_err++; return; end
            L = dg[pos];
            if (L < 2) begin
                m_err++;
                if (m >= skip) m_prst++;
                return;
            end
            if (pos + L > n) begin
                m_err++;
                if (m >= skip) begin
                    for (int j = pos; j < n; j++) fw[j] = 1'b1;
                    m_prst++;
                end
                return;
            end
            if (m >= skip) for (int j = pos; j < pos + L; j++) fw[j] = 1'b1;
            pos += L;
        end
    endtask

    task automatic build(input logic [7:0] cnt, input logic [7:0] unit, input logic [31:0] seq);
        int tot = 8;
        foreach (lens[i]) tot += lens[i];
        dg.delete();
        dg.push_back(8'(tot));
        dg.push_back(8'(tot >> 8));
        dg.push_back(cnt);
        dg.push_back(unit);
        for (int b = 0; b < 4; b++) dg.push_back(8'(seq >> (8 * b)));
        foreach (lens[i]) begin
            dg.push_back(8'(lens[i]));
            for (int j = 1; j < lens[i]; j++) dg.push_back(8'($urandom));
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit f);
        exp_t e;
        int   waitc = 0;
        udp_data  = d;
        udp_valid = 1'b1;
        udp_last  = l;
        forever begin
            @(negedge clk);
            if (f && parser_data_valid && !parser_ready) chk("ready_while_held", udp_ready, 1'b0);
            if (udp_ready) break;
            waitc++;
            if (waitc > 200) begin
                chk("accept_timeout", waitc, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (f && udp_ready) begin
            e.d   = d;
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        udp_valid = 1'b0;
        udp_last  = 1'b0;
    endtask

    task automatic settle();
        int w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_status();
        chk("expected_seq", expected_seq, m_exp);
        chk("gap_count", gap_count, m_gap);
        chk("dup_count", dup_count, m_dup);
        chk("err_count", err_count, m_err);
        chk("parser_reset_pulses", prst_seen, m_prst);
        chk("w2_gap_count", d2_gap, sat3(m_gap));
        chk("w2_dup_count", d2_dup, sat3(m_dup));
        chk("w2_err_count", d2_err, sat3(m_err));
    endtask

    task automatic run(input bit bubbles);
        int pred = 0;
        model_dgram();
        foreach (fw[i]) if (fw[i]) pred++;
        out_cnt = 0;
        for (int i = 0; i < dg.size(); i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(dg[i], i == dg.size() - 1, fw[i]);
        end
        settle();
        chk("fwd_bytes", out_cnt, pred);
        check_status();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        udp_valid = 1'b0;
        udp_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_udp_ready", udp_ready, 1'b0);
        chk("rst_pdv", parser_data_valid, 1'b0);
        chk("rst_pdata", parser_data, 8'd0);
        chk("rst_preset", parser_reset, 1'b0);
        chk("rst_exp_seq", expected_seq, 32'd1);
        chk("rst_counters", {gap_count, dup_count, err_count}, 48'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        prst_seen = 0;
        exp_q.delete();
        m_exp = 1; m_gap = 0; m_dup = 0; m_err = 0; m_prst = 1;
    endtask

    initial begin
        longint s;
        int     n_extra;
        reset_n   = 1'b0;
        cfg_unit  = CFG;
        udp_data  = 8'd0;
        udp_valid = 1'b0;
        udp_last  = 1'b0;
        do_reset();
        settle();
        chk("post_reset_pulse", prst_seen, 1);

        lens = '{26, 14};
        build(8'd2, 8'd1, 32'd1);
        run(1'b0);
        chk("first_dgram_bytes", out_cnt, 40);
        chk("first_dgram_seq", expected_seq, 32'd3);

        run(1'b0);
        chk("repeat_bytes", out_cnt, 0);
        chk("repeat_dup", dup_count, 1);

        lens = '{26};
        build(8'd1, 8'd1, 32'd5);
        run(1'b0);
        chk("gap_bytes", out_cnt, 26);
        chk("gap_seq", expected_seq, 32'd6);

        lens = '{26, 14, 20};
        build(8'd3, 8'd1, 32'd4);
        run(1'b0);
        chk("overlap_bytes", out_cnt, 20);
        chk("overlap_seq", expected_seq, 32'd7);
        chk("overlap_dup", dup_count, 2);

        rnd_rdy = 1'b1;
        lens = '{26, 14, 33};
        build(8'd3, 8'd1, 32'(m_exp));
        run(1'b0);
        rnd_rdy = 1'b0;

        lens = '{26, 14};
        build(8'd2, 8'd1, 32'(m_exp));
        repeat (30) void'(dg.pop_back());
        run(1'b0);
        chk("trunc_err", err_count, 1);

        lens = '{26};
        build(8'd1, 8'd2, 32'(m_exp));
        run(1'b0);
        chk("other_unit_bytes", out_cnt, 0);

        dg = '{8'd5, 8'd0, 8'd1, 8'd1, 8'd9};
        run(1'b0);
        chk("runt_bytes", out_cnt, 0);

        lens = '{14};
        build(8'd1, 8'd1, 32'd1);
        repeat (5) run(1'b0);
        chk("w2_dup_saturated", d2_dup, 2'd3);

        lens = '{20, 1, 14};
        build(8'd3, 8'd1, 32'(m_exp));
        run(1'b0);

        // wrap of expected_seq past 2^32
        lens = '{10, 12, 14};
        build(8'd3, 8'd1, 32'hFFFF_FFFE);
        run(1'b0);
        lens = '{10, 12};
        build(8'd2, 8'd1, 32'd0);
        run(1'b0);
        chk("wrap_seq", expected_seq, 32'd2);

        rnd_rdy = 1'b1;
        for (int k = 0; k < 25; k++) begin
            lens.delete();
            for (int m = 0; m < $urandom_range(0, 4); m++) lens.push_back($urandom_range(2, 30));
            if (lens.size() > 1 && $urandom_range(0, 7) == 0) lens[1] = 1;
            s = m_exp + $urandom_range(0, 6) - 3;
            build(8'(lens.size()), ($urandom_range(0, 7) == 0) ? 8'd2 : CFG, s[31:0]);
            if ($urandom_range(0, 5) == 0) begin
                n_extra = $urandom_range(1, dg.size() - 1);
                repeat (n_extra) void'(dg.pop_back());
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) dg.push_back(8'($urandom));
            end
            run(1'b1);
        end
        rnd_rdy = 1'b0;

        lens = '{20};
        build(8'd1, 8'd1, 32'(m_exp));
        for (int i = 0; i < 4; i++) send_byte(dg[i], 1'b0, 1'b0);
        do_reset();
        settle();
        chk("midhdr_reset_pulse", prst_seen, 1);
        build(8'd1, 8'd1, 32'd1);
        run(1'b0);
        chk("after_reset_bytes", out_cnt, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
